// File: rtl/aes_mmio_resp.sv
// rtl/aes_mmio_resp.sv - MMIO responder holding AES key/block/result registers and sequencing the AES core
module aes_mmio_resp #(
  parameter int AW = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic         stall_o,
  output logic         ready_o,
  output logic [31:0]  rdata_o,
  output logic         aes_start_o,
  output logic         aes_dec_o,
  output logic [127:0] aes_key_o,
  output logic [127:0] aes_block_o,
  input  logic         aes_done_i,
  input  logic [127:0] aes_result_i
);

  localparam int OW = AW - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] key  [4];
  logic [31:0] din  [4];
  logic [31:0] dout [4];
  logic        dec;
  logic        done;
  logic        err;
  logic        busy;

  // Word offset splits into a 4-word group and an index within the group.
  logic [OW-1:0] offset;
  logic [OW-3:0] grp;
  logic [1:0]    idx;
  logic          unused_addr;

  assign offset      = addr_i[AW-1:2];
  assign grp         = offset[OW-1:2];
  assign idx         = offset[1:0];
  assign unused_addr = ^{addr_i[31:AW], addr_i[1:0]};

  logic is_key, is_din, is_dout, is_ctrl, is_status;
  assign is_key    = (grp == (OW-2)'(0));
  assign is_din    = (grp == (OW-2)'(1));
  assign is_dout   = (grp == (OW-2)'(2));
  assign is_ctrl   = (grp == (OW-2)'(3)) && (idx == 2'd0);
  assign is_status = (grp == (OW-2)'(3)) && (idx == 2'd1);

  assign busy    = (state != S_IDLE);
  // Only a result read can be stalled: it waits until the core has produced data.
  assign stall_o = valid_i && !we_i && busy && is_dout;

  logic accept, wr, rd, err_set, start_req;
  assign accept    = valid_i && !stall_o;
  assign wr        = accept && we_i;
  assign rd        = accept && !we_i;
  assign err_set   = wr && busy && (is_key || is_din || is_ctrl);
  assign start_req = wr && !busy && is_ctrl && wdata_i[0];

  assign aes_dec_o   = dec;
  assign aes_key_o   = {key[0], key[1], key[2], key[3]};
  assign aes_block_o = {din[0], din[1], din[2], din[3]};

  // Read mux evaluated on pre-edge register values.
  logic [31:0] rmux;
  always_comb begin
    rmux = 32'h0;
    if (is_key)         rmux = key[idx];
    else if (is_din)    rmux = din[idx];
    else if (is_dout)   rmux = dout[idx];
    else if (is_ctrl)   rmux = {30'h0, dec, 1'b0};
    else if (is_status) rmux = {29'h0, err, done, busy};
  end

  // Sequencer next state and the one-cycle start pulse.
  always_comb begin
    state_nxt   = state;
    aes_start_o = 1'b0;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_START;
      S_START: begin
        aes_start_o = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT:  if (aes_done_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Register file, access response and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        key[i]  <= 32'h0;
        din[i]  <= 32'h0;
        dout[i] <= 32'h0;
      end
      dec     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ready_o <= 1'b0;
      rdata_o <= 32'h0;
    end else begin
      ready_o <= accept;
      rdata_o <= rd ? rmux : 32'h0;
      // Operand writes are only honoured while idle so the core sees stable inputs.
      if (wr && !busy) begin
        if (is_key)  key[idx] <= wdata_i;
        if (is_din)  din[idx] <= wdata_i;
        if (is_ctrl) dec      <= wdata_i[1];
      end
      if (start_req) done <= 1'b0;
      if (state == S_WAIT && aes_done_i) begin
        dout[0] <= aes_result_i[127:96];
        dout[1] <= aes_result_i[95:64];
        dout[2] <= aes_result_i[63:32];
        dout[3] <= aes_result_i[31:0];
        done    <= 1'b1;
      end
      // A same-cycle set beats the W1C clear.
      if (err_set)                            err <= 1'b1;
      else if (wr && is_status && wdata_i[2]) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_mmio_resp.sv
// tb/tb_aes_mmio_resp.sv - directed self-checking bench for aes_mmio_resp
module tb_aes_mmio_resp;

  logic         clk;
  logic         rst;
  logic         valid;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         stall;
  logic         ready;
  logic [31:0]  rdata;
  logic         aes_start;
  logic         aes_dec;
  logic [127:0] aes_key;
  logic [127:0] aes_block;
  logic         aes_done;
  logic [127:0] aes_result;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;

  localparam logic [127:0] KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] DIN = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] RES = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] RES2 = 128'ha1b2c3d4_e5f60718_293a4b5c_6d7e8f90;

  aes_mmio_resp #(.AW(6)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall),
    .ready_o      (ready),
    .rdata_o      (rdata),
    .aes_start_o  (aes_start),
    .aes_dec_o    (aes_dec),
    .aes_key_o    (aes_key),
    .aes_block_o  (aes_block),
    .aes_done_i   (aes_done),
    .aes_result_i (aes_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start pulses counted mid-cycle.
  always @(negedge clk) if (aes_start) start_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    valid = 1'b0; we = 1'b0;
    check("wr_ready", 128'(ready), 128'(1'b1));
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    valid = 1'b1; we = 1'b0; addr = a;
    #1;
    n = 0;
    while (stall && n < 100) begin
      tick();
      n++;
    end
    if (stall) check("rd_stall_timeout", 128'(stall), 128'(1'b0));
    tick();
    valid = 1'b0;
    check("rd_ready", 128'(ready), 128'(1'b1));
    d = rdata;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; valid = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    aes_done = 1'b0; aes_result = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    check("rst_start", 128'(aes_start), 128'(0));
    check("rst_dec", 128'(aes_dec), 128'(0));
    check("rst_key", aes_key, 128'h0);
    check("rst_block", aes_block, 128'h0);
    check("rst_stall", 128'(stall), 128'(0));

    // Every mapped register reads zero after reset.
    for (int a = 0; a <= 32'h34; a += 4) begin
      do_read(32'(a), d);
      check("rd_zero", 128'(d), 128'(0));
    end
    tick();
    check("ready_idle", 128'(ready), 128'(0));

    // Load operands and run one operation.
    for (int i = 0; i < 4; i++) do_write(32'(i * 4), KEY[127 - 32*i -: 32]);
    for (int i = 0; i < 4; i++) do_write(32'(16 + i * 4), DIN[127 - 32*i -: 32]);
    check("key_out", aes_key, KEY);
    check("block_out", aes_block, DIN);
    do_read(32'h04, d);
    check("rd_key1", 128'(d), 128'h28aed2a6);
    do_write(32'h30, 32'h1);
    check("start_pulse", 128'(aes_start), 128'(1));
    check("start_key", aes_key, KEY);
    check("start_block", aes_block, DIN);
    tick();
    check("start_one_cycle", 128'(aes_start), 128'(0));
    repeat (8) tick();
    aes_done = 1'b1; aes_result = RES;
    tick();
    aes_done = 1'b0; aes_result = 128'h0;
    check("start_count1", 128'(start_cnt), 128'(1));
    do_read(32'h34, d);
    check("status_done", 128'(d), 128'h2);
    for (int i = 0; i < 4; i++) begin
      do_read(32'(32 + i * 4), d);
      check("dout_word", 128'(d), 128'(RES[127 - 32*i -: 32]));
    end

    // DOUT2 read issued right after start stalls until the result is captured.
    do_write(32'h30, 32'h1);
    valid = 1'b1; we = 1'b0; addr = 32'h28;
    #1;
    check("stall_start", 128'(stall), 128'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_wait", 128'(stall), 128'(1));
      check("stall_no_ready", 128'(ready), 128'(0));
    end
    aes_done = 1'b1; aes_result = RES2;
    #1;
    check("stall_done_cycle", 128'(stall), 128'(1));
    tick();
    aes_done = 1'b0; aes_result = 128'h0;
    check("stall_released", 128'(stall), 128'(0));
    check("ready_not_yet", 128'(ready), 128'(0));
    tick();
    valid = 1'b0;
    check("stall_rd_ready", 128'(ready), 128'(1));
    check("stall_rd_data", 128'(rdata), 128'h293a4b5c);
    tick();
    check("stall_one_ready", 128'(ready), 128'(0));

    // Writes while busy are discarded and flag err.
    do_write(32'h30, 32'h1);
    do_write(32'h04, 32'hdeadbeef);
    check("busy_key_hold", aes_key, KEY);
    do_write(32'h30, 32'h3);
    check("busy_dec_hold", 128'(aes_dec), 128'(0));
    do_read(32'h34, d);
    check("status_busy_err", 128'(d), 128'h5);
    aes_done = 1'b1; aes_result = RES;
    tick();
    aes_done = 1'b0;
    check("no_extra_start", 128'(start_cnt), 128'(3));
    do_write(32'h34, 32'h4);
    do_read(32'h34, d);
    check("status_err_clr", 128'(d), 128'h2);

    // CTRL with bit0 clear only updates dec.
    do_write(32'h30, 32'h2);
    tick();
    check("dec_set", 128'(aes_dec), 128'(1));
    check("dec_no_start", 128'(start_cnt), 128'(3));
    do_read(32'h30, d);
    check("ctrl_read", 128'(d), 128'h2);

    // Reset while waiting abandons the operation.
    do_write(32'h30, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    aes_done = 1'b1; aes_result = RES;
    tick();
    aes_done = 1'b0;
    do_read(32'h20, d);
    check("rst_wait_dout", 128'(d), 128'h0);
    do_read(32'h34, d);
    check("rst_wait_status", 128'(d), 128'h0);
    check("rst_wait_key", aes_key, 128'h0);
    check("rst_wait_dec", 128'(aes_dec), 128'(0));

    // Unmapped offsets.
    do_write(32'h00, 32'h12345678);
    do_write(32'h38, 32'hffffffff);
    do_read(32'h3c, d);
    check("unmapped_rd", 128'(d), 128'h0);
    check("unmapped_key", aes_key, {32'h12345678, 96'h0});
    check("unmapped_block", aes_block, 128'h0);
    do_read(32'h34, d);
    check("unmapped_status", 128'(d), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
